branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with per-entry saturating direction counters.
// The fetch stage looks up combinationally from the current table contents.
// The decode stage trains or allocates one entry per cycle and also counts
// mispredictions. A lookup and an update in the same cycle see the old table.
module branch_predictor #(
    parameter int ENTRIES     = 16,
    parameter int CNT_W       = 2,
    parameter bit STATIC_MISS = 1'b1
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:0] iPCF,
    input  logic        iStaticTakeF,
    input  logic [31:0] iStaticTargetF,
    input  logic        iUpdateEnD,
    input  logic [31:0] iUpdatePCD,
    input  logic        iUpdateTakenD,
    input  logic [31:0] iUpdateTargetD,
    input  logic        iMispredictD,
    output logic        oPredTakeF,
    output logic [31:0] oPredTargetF,
    output logic        oHitF,
    output logic [31:0] oMispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Counter values for a weakly-taken and a weakly-not-taken entry.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic [31:0]      mis_cnt_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [CNT_W-1:0] cnt_next;

    // The two low PC bits are always zero for aligned instructions, so they
    // take no part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{iPCF[1:0], iUpdatePCD[1:0]};

    assign f_idx = iPCF[IDX_W+1:2];
    assign f_tag = iPCF[31:IDX_W+2];
    assign u_idx = iUpdatePCD[IDX_W+1:2];
    assign u_tag = iUpdatePCD[31:IDX_W+2];

    // Fetch-side lookup: a hit uses the table, a miss falls back to the static guess.
    always_comb begin
        oHitF        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        oPredTakeF   = 1'b0;
        oPredTargetF = iStaticTargetF;
        if (oHitF) begin
            oPredTakeF   = cnt_q[f_idx][CNT_W-1];
            oPredTargetF = target_q[f_idx];
        end else if (STATIC_MISS) begin
            oPredTakeF   = iStaticTakeF;
        end
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        cnt_next = cnt_q[u_idx];
        if (iUpdateTakenD) begin
            if (cnt_q[u_idx] != CNT_MAX) cnt_next = cnt_q[u_idx] + CNT_W'(1);
        end else begin
            if (cnt_q[u_idx] != '0) cnt_next = cnt_q[u_idx] - CNT_W'(1);
        end
    end

    // Table state: reset clears everything, otherwise train on a hit or allocate on a miss.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (iUpdateEnD) begin
            if (u_hit) begin
                cnt_q[u_idx] <= cnt_next;
                if (iUpdateTakenD) target_q[u_idx] <= iUpdateTargetD;
            end else begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= iUpdateTargetD;
                cnt_q[u_idx]    <= iUpdateTakenD ? CNT_WT : CNT_WNT;
            end
        end
    end

    // Misprediction counter, saturating at all-ones.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            mis_cnt_q <= '0;
        end else if (iUpdateEnD && iMispredictD && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign oMispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16, CNT_W=2, STATIC_MISS=1).
// Inputs change on the falling edge; outputs are checked just before the next
// rising edge, so each row's expectations reflect the table before that row's update.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        static_take;
    logic [31:0] static_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        mispredict;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        hit;
    logic [31:0] mis_count;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .STATIC_MISS(1'b1)) dut (
        .iClk            (clk),
        .iRstN           (rst_n),
        .iPCF            (pc_f),
        .iStaticTakeF    (static_take),
        .iStaticTargetF  (static_target),
        .iUpdateEnD      (upd_en),
        .iUpdatePCD      (upd_pc),
        .iUpdateTakenD   (upd_taken),
        .iUpdateTargetD  (upd_target),
        .iMispredictD    (mispredict),
        .oPredTakeF      (pred_take),
        .oPredTargetF    (pred_target),
        .oHitF           (hit),
        .oMispredictCount(mis_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic        st_take;
        logic [31:0] st_tgt;
        logic        upd_en;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_tgt;
        logic        mis;
        logic        chk;
        logic        exp_hit;
        logic        exp_take;
        logic [31:0] exp_tgt;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic [31:0] pc, logic st, logic [31:0] stt,
                                logic ue, logic [31:0] upc, logic ut, logic [31:0] utg,
                                logic mis, logic chk, logic eh, logic et,
                                logic [31:0] etg, logic [31:0] ec);
        vec_t v;
        v.rst_n = r;   v.pc = pc;      v.st_take = st;   v.st_tgt = stt;
        v.upd_en = ue; v.upd_pc = upc; v.upd_taken = ut; v.upd_tgt = utg;
        v.mis = mis;   v.chk = chk;    v.exp_hit = eh;   v.exp_take = et;
        v.exp_tgt = etg; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic st,
                         input logic [31:0] stt, input logic ue, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg, input logic mis);
        rst_n = r; pc_f = pc; static_take = st; static_target = stt;
        upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utg; mispredict = mis;
    endtask

    task automatic check_out(input string tag, input logic eh, input logic et,
                             input logic [31:0] etg, input logic [31:0] ec);
        check({tag, " hit"},    {31'd0, hit},       {31'd0, eh});
        check({tag, " take"},   {31'd0, pred_take}, {31'd0, et});
        check({tag, " target"}, pred_target,        etg);
        check({tag, " miscnt"}, mis_count,          ec);
    endtask

    initial begin
        //          rst pc        st  st_tgt    ue  upd_pc    ut  upd_tgt   mis chk hit tk  exp_tgt   cnt
        vecs[0]  = mk(0, 32'h100, 1, 32'h0F0, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h000, 0);
        vecs[1]  = mk(1, 32'h100, 1, 32'h0F0, 0, 32'h000, 0, 32'h000, 0, 1, 0, 1, 32'h0F0, 0);
        vecs[2]  = mk(1, 32'h040, 0, 32'h044, 1, 32'h040, 1, 32'h020, 0, 1, 0, 0, 32'h044, 0);
        vecs[3]  = mk(1, 32'h040, 0, 32'h044, 1, 32'h040, 1, 32'h020, 0, 1, 1, 1, 32'h020, 0);
        vecs[4]  = mk(1, 32'h040, 0, 32'h044, 1, 32'h040, 1, 32'h020, 0, 1, 1, 1, 32'h020, 0);
        vecs[5]  = mk(1, 32'h040, 0, 32'h044, 1, 32'h040, 0, 32'h999, 0, 1, 1, 1, 32'h020, 0);
        vecs[6]  = mk(1, 32'h040, 0, 32'h044, 1, 32'h040, 0, 32'h888, 0, 1, 1, 1, 32'h020, 0);
        vecs[7]  = mk(1, 32'h040, 1, 32'h500, 0, 32'h040, 1, 32'h777, 0, 1, 1, 0, 32'h020, 0);
        vecs[8]  = mk(1, 32'h040, 1, 32'h500, 1, 32'h080, 1, 32'h200, 0, 1, 1, 0, 32'h020, 0);
        vecs[9]  = mk(1, 32'h040, 1, 32'h044, 0, 32'h000, 0, 32'h000, 0, 1, 0, 1, 32'h044, 0);
        vecs[10] = mk(1, 32'h080, 0, 32'h084, 0, 32'h000, 0, 32'h000, 0, 1, 1, 1, 32'h200, 0);
        vecs[11] = mk(1, 32'h300, 0, 32'h304, 1, 32'h300, 1, 32'h340, 1, 1, 0, 0, 32'h304, 0);
        vecs[12] = mk(1, 32'h300, 0, 32'h304, 1, 32'h300, 0, 32'h111, 1, 1, 1, 1, 32'h340, 1);
        vecs[13] = mk(1, 32'h300, 1, 32'h304, 0, 32'h300, 1, 32'h222, 1, 1, 1, 0, 32'h340, 2);
        vecs[14] = mk(1, 32'h300, 1, 32'h304, 1, 32'h104, 1, 32'h008, 1, 1, 1, 0, 32'h340, 2);
        vecs[15] = mk(0, 32'h104, 0, 32'h108, 1, 32'h104, 1, 32'h00C, 1, 1, 1, 1, 32'h008, 3);
        vecs[16] = mk(1, 32'h104, 0, 32'h108, 0, 32'h000, 0, 32'h000, 0, 1, 0, 0, 32'h108, 0);
        vecs[17] = mk(1, 32'h300, 1, 32'h001, 0, 32'h000, 0, 32'h000, 0, 1, 0, 1, 32'h001, 0);
        vecs[18] = mk(1, 32'h040, 0, 32'h044, 0, 32'h000, 0, 32'h000, 0, 1, 0, 0, 32'h044, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].pc, vecs[i].st_take, vecs[i].st_tgt, vecs[i].upd_en,
                  vecs[i].upd_pc, vecs[i].upd_taken, vecs[i].upd_tgt, vecs[i].mis);
            #2;
            if (vecs[i].chk)
                check_out($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_take,
                          vecs[i].exp_tgt, vecs[i].exp_cnt);
        end

        // Counter floor: allocate not-taken (1), two more not-taken (0, stays 0),
        // then taken twice (1, 2). Each row checks the state left by the previous update.
        @(negedge clk); drive(1, 32'h010, 1, 32'h0AA, 1, 32'h010, 0, 32'h0C0, 0);
        #2; check_out("floor alloc", 0, 1, 32'h0AA, 0);
        @(negedge clk); drive(1, 32'h010, 1, 32'h0AA, 1, 32'h010, 0, 32'h0D0, 0);
        #2; check_out("floor c1", 1, 0, 32'h0C0, 0);
        @(negedge clk); drive(1, 32'h010, 1, 32'h0AA, 1, 32'h010, 0, 32'h0D0, 0);
        #2; check_out("floor c0", 1, 0, 32'h0C0, 0);
        @(negedge clk); drive(1, 32'h010, 1, 32'h0AA, 1, 32'h010, 1, 32'h0E0, 0);
        #2; check_out("floor sat", 1, 0, 32'h0C0, 0);
        @(negedge clk); drive(1, 32'h010, 1, 32'h0AA, 1, 32'h010, 1, 32'h0E0, 0);
        #2; check_out("floor up1", 1, 0, 32'h0E0, 0);
        @(negedge clk); drive(1, 32'h010, 0, 32'h0AA, 0, 32'h000, 0, 32'h000, 0);
        #2; check_out("floor up2", 1, 1, 32'h0E0, 0);

        // Reset coincident with an update of a new PC: reset must win.
        @(negedge clk); drive(0, 32'h014, 0, 32'h0BB, 1, 32'h014, 1, 32'h0F4, 1);
        @(negedge clk); drive(1, 32'h014, 0, 32'h0BB, 0, 32'h000, 0, 32'h000, 0);
        #2; check_out("rst prio", 0, 0, 32'h0BB, 0);
        @(negedge clk); drive(1, 32'h010, 1, 32'h0AA, 0, 32'h000, 0, 32'h000, 0);
        #2; check_out("rst clear", 0, 1, 32'h0AA, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
